// File: rtl/spike_seq_pkg.sv
// spike_seq_pkg: shared state encoding, skid/latency constants and FIFO entry layout
// for the spike sequencer.
package spike_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_REST, ST_DONE} state_e;
    localparam int SKID_DEPTH  = 2;
    localparam int ROM_LATENCY = 1;
    // Layout for the default build; the sequencer passes its own sized entry type to the FIFO.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  step;
        logic        last;
    } spk_entry_t;
endpackage

// File: rtl/spike_sequencer_if.sv
// spike_sequencer_if: valid/ready spike-word stream from sequencer (master) to neuron layer (slave).
interface spike_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 4
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [STEP_W-1:0] step;
    logic              last;
    modport master (output valid, data, step, last, input ready);
    modport slave  (input valid, data, step, last, output ready);
endinterface

// File: rtl/spike_skid_fifo.sv
// spike_skid_fifo: 2-entry FIFO absorbing the ROM read latency; head is shown combinationally.
module spike_skid_fifo
    import spike_seq_pkg::*;
#(
    parameter type T = spk_entry_t
)(
    input  logic       clk,
    input  logic       rst_l,
    input  logic       i_push,
    input  T           i_data,
    input  logic       i_pop,
    output T           o_head,
    output logic [1:0] o_count
);
    T           r_mem [SKID_DEPTH];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_count;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_mem[r_wr] <= i_data;
            r_wr    <= r_wr ^ i_push;
            r_rd    <= r_rd ^ i_pop;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
        !(i_push && !i_pop && r_count == 2'(SKID_DEPTH)));
endmodule

// File: rtl/spike_sequencer.sv
// spike_sequencer: streams ROM spike words per sample with timestep tags and a rest window.
// Define SPIKE_SEQ_LOOP_EN to loop epochs forever (adds epoch_cnt, done becomes a pulse).
module spike_sequencer
    import spike_seq_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int STEPS       = 16,
    parameter int NUM_SAMPLES = 256,
    parameter int REST_CYCLES = 4
)(
    input  logic              clk,
    input  logic              rst_l,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    spike_sequencer_if.master spk,
    output logic [15:0]       sample_idx,
    output logic              layer_clear,
    output logic              busy,
    output logic              done
`ifdef SPIKE_SEQ_LOOP_EN
    ,output logic [7:0]       epoch_cnt
`endif
);
    localparam int STEP_W = $clog2(STEPS);
    localparam int CNT_W  = STEP_W + 1;
    localparam int REST_W = $clog2(REST_CYCLES + 1);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] REST  = ST_REST;
    localparam logic [1:0] DONE  = ST_DONE;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STEP_W-1:0] step;
        logic              last;
    } entry_t;

    if (STEPS < 2 || (STEPS & (STEPS - 1)) != 0) begin : g_bad_steps
        $error("STEPS must be a power of two >= 2");
    end
    if (longint'(NUM_SAMPLES) * longint'(STEPS) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("NUM_SAMPLES*STEPS exceeds the ROM address space");
    end
    if (REST_CYCLES < 1) begin : g_bad_rest
        $error("REST_CYCLES must be >= 1");
    end
    if (ROM_LATENCY != 1) begin : g_bad_lat
        $error("a single inflight flag only covers a one-cycle ROM");
    end

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_issued;
    logic              r_inflight;
    logic [STEP_W-1:0] r_inflight_step;
    logic [REST_W-1:0] r_rest;
    logic [15:0]       r_sample;
    logic              r_done;
    logic [1:0]        w_count;
    entry_t            w_head;
    entry_t            w_push_entry;
    logic              w_valid;
    logic              w_hs;
    logic              w_start;
    logic              w_rest_exp;
    logic              w_last_sample;
    logic              w_room;
    logic              w_issue;

    assign w_valid       = w_count != 2'd0;
    assign w_hs          = w_valid && spk.ready;
    assign w_start       = start && (r_state == IDLE || r_state == DONE);
    assign w_rest_exp    = r_state == REST && r_rest == REST_W'(1);
    assign w_last_sample = r_sample == 16'(NUM_SAMPLES - 1);
    assign w_room        = ({1'b0, w_count} + {2'b00, r_inflight}) < 3'(SKID_DEPTH);
    // The next sample's first read goes out on the same edge the rest window closes.
    assign w_issue       = (r_state == FETCH && r_issued < CNT_W'(STEPS) && (w_room || w_hs))
                        || (w_rest_exp && !w_last_sample);
    assign w_push_entry  = '{data: rom_data, step: r_inflight_step,
                             last: r_inflight_step == STEP_W'(STEPS - 1)};

    spike_skid_fifo #(.T(entry_t)) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_push  (r_inflight),
        .i_data  (w_push_entry),
        .i_pop   (w_hs),
        .o_head  (w_head),
        .o_count (w_count)
    );

`ifdef SPIKE_SEQ_LOOP_EN
    logic [7:0] r_epoch;
    assign epoch_cnt = r_epoch;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_step <= '0;
            r_rest          <= '0;
            r_sample        <= '0;
            r_done          <= 1'b0;
`ifdef SPIKE_SEQ_LOOP_EN
            r_epoch         <= 8'd0;
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_step <= r_issued[STEP_W-1:0];
`ifdef SPIKE_SEQ_LOOP_EN
            r_done          <= 1'b0;
`endif
            if (w_issue) begin
                r_addr   <= r_addr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
            if (w_start) begin
                r_state  <= FETCH;
                r_addr   <= '0;
                r_issued <= '0;
                r_sample <= '0;
                r_done   <= 1'b0;
            end else if (r_state == FETCH && w_hs && w_head.last) begin
                r_state  <= REST;
                r_rest   <= REST_W'(REST_CYCLES);
                r_issued <= '0;
            end else if (w_rest_exp && !w_last_sample) begin
                r_state  <= FETCH;
                r_sample <= r_sample + 16'd1;
            end else if (w_rest_exp) begin
`ifdef SPIKE_SEQ_LOOP_EN
                r_state  <= FETCH;
                r_addr   <= '0;
                r_sample <= '0;
                r_done   <= 1'b1;
                r_epoch  <= r_epoch + 8'd1;
`else
                r_state  <= DONE;
                r_done   <= 1'b1;
`endif
            end else if (r_state == REST) begin
                r_rest <= r_rest - 1'b1;
            end
        end
    end

    assign rom_addr    = r_addr;
    assign spk.valid   = w_valid;
    assign spk.data    = w_head.data;
    assign spk.step    = w_head.step;
    assign spk.last    = w_head.last;
    assign sample_idx  = r_sample;
    assign layer_clear = r_state == REST;
    assign busy        = r_state == FETCH || r_state == REST;
    assign done        = r_done;
endmodule

// File: tb/tb_spike_sequencer.sv
// tb_spike_sequencer: directed checks of streaming, backpressure, stall, ignored start and mid-run reset.
module tb_spike_sequencer;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int STEPS       = 4;
    localparam int NUM_SAMPLES = 2;
    localparam int REST_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [15:0]       sample_idx;
    logic              layer_clear;
    logic              busy;
    logic              done;
`ifdef SPIKE_SEQ_LOOP_EN
    logic [7:0]        epoch_cnt;
`endif
    int n_checks = 0;
    int n_fail = 0;

    spike_sequencer_if #(.DATA_W(DATA_W), .STEP_W(2)) spk ();

    spike_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEPS(STEPS),
        .NUM_SAMPLES(NUM_SAMPLES), .REST_CYCLES(REST_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .spk         (spk),
        .sample_idx  (sample_idx),
        .layer_clear (layer_clear),
        .busy        (busy),
        .done        (done)
`ifdef SPIKE_SEQ_LOOP_EN
        ,.epoch_cnt  (epoch_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int a);
        return {16'(a) ^ 16'hA55A, 16'(a)};
    endfunction

    // Registered ROM: data for the sampled address appears one cycle later.
    always @(posedge clk) rom_data <= word(int'(rom_addr));

    task automatic do_reset;
        rst_l = 1'b0;
        start = 1'b0;
        spk.ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge after the start edge (cycle c=0).
    task automatic kick;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        spk.ready = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout got done=%b want 1", name, done);
        end
    endtask

    task automatic test_reset;
        rst_l = 1'b0;
        spk.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({spk.valid, layer_clear, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {spk.valid, layer_clear, busy, done});
        end
        n_checks++;
        if (rom_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_addr got %0d want 0", rom_addr);
        end
        n_checks++;
        if (sample_idx !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_sample got %0d want 0", sample_idx);
        end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream;
        do_reset();
        spk.ready = 1'b1;
        kick();
        for (int c = 0; c < 19; c++) begin
            logic       ev = (c >= 2 && c <= 5) || (c >= 11 && c <= 14);
            logic       ec = (c >= 6 && c <= 9) || (c >= 15 && c <= 18);
            int         ea = c <= 4 ? c : (c < 10 ? 4 : (c <= 13 ? c - 5 : 8));
            int         wi = c <= 5 ? c - 2 : c - 7;
            n_checks++;
            if ({spk.valid, layer_clear, busy, done} !== {ev, ec, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stream_flags_c%0d got %b want %b", c,
                         {spk.valid, layer_clear, busy, done}, {ev, ec, 1'b1, 1'b0});
            end
            n_checks++;
            if (rom_addr !== 16'(ea) || sample_idx !== 16'(c >= 10)) begin
                n_fail++;
                $display("FAIL stream_addr_c%0d got addr=%0d sample=%0d want addr=%0d sample=%0d",
                         c, rom_addr, sample_idx, ea, c >= 10);
            end
            if (ev) begin
                n_checks++;
                if ({spk.data, spk.step, spk.last} !== {word(wi), 2'(wi), wi % 4 == 3}) begin
                    n_fail++;
                    $display("FAIL stream_word_c%0d got %h/%0d/%b want %h/%0d/%b", c,
                             spk.data, spk.step, spk.last, word(wi), wi % 4, wi % 4 == 3);
                end
            end
            @(negedge clk);
        end
`ifndef SPIKE_SEQ_LOOP_EN
        n_checks++;
        if ({done, busy, layer_clear, spk.valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stream_done got %b want 1000", {done, busy, layer_clear, spk.valid});
        end
`endif
    endtask

    task automatic test_backpressure;
        int          idx = 0;
        int          cyc = 0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [31:0] pd = '0;
        do_reset();
        kick();
        while (done !== 1'b1 && cyc < 400) begin
            if (pv && !pr) begin
                n_checks++;
                if (spk.valid !== 1'b1 || spk.data !== pd) begin
                    n_fail++;
                    $display("FAIL bp_hold got %b/%h want 1/%h", spk.valid, spk.data, pd);
                end
            end
            n_checks++;
            if (int'(rom_addr) > idx + 2) begin
                n_fail++;
                $display("FAIL bp_addr got %0d want <= %0d", rom_addr, idx + 2);
            end
            spk.ready = 1'($urandom_range(0, 1));
            if (spk.valid && spk.ready) begin
                n_checks++;
                if ({spk.data, spk.step, spk.last} !== {word(idx), 2'(idx), idx % 4 == 3}) begin
                    n_fail++;
                    $display("FAIL bp_word%0d got %h/%0d/%b want %h/%0d/%b", idx,
                             spk.data, spk.step, spk.last, word(idx), idx % 4, idx % 4 == 3);
                end
                idx++;
            end
            pv = spk.valid;
            pr = spk.ready;
            pd = spk.data;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || idx != 8) begin
            n_fail++;
            $display("FAIL bp_total got done=%b words=%0d want done=1 words=8", done, idx);
        end
    endtask

    task automatic test_stall;
        do_reset();
        spk.ready = 1'b1;
        kick();
        repeat (3) @(negedge clk);
        spk.ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({spk.valid, spk.data, rom_addr} !== {1'b1, word(1), 16'd3}) begin
                n_fail++;
                $display("FAIL stall_%0d got %b/%h/addr=%0d want 1/%h/addr=3", i,
                         spk.valid, spk.data, rom_addr, word(1));
            end
            @(negedge clk);
        end
        spk.ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if ({spk.valid, spk.data, spk.last} !== {1'b1, word(k), k == 3}) begin
                n_fail++;
                $display("FAIL stall_resume%0d got %b/%h/%b want 1/%h/%b", k,
                         spk.valid, spk.data, spk.last, word(k), k == 3);
            end
            @(negedge clk);
        end
        wait_done("stall");
    endtask

    task automatic test_start_ignored;
        do_reset();
        spk.ready = 1'b1;
        kick();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({spk.data, rom_addr, sample_idx, busy} !== {word(2), 16'd4, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL start_ignored got %h/addr=%0d/s=%0d/%b want %h/addr=4/s=0/1",
                     spk.data, rom_addr, sample_idx, busy, word(2));
        end
        @(negedge clk);
        n_checks++;
        if ({spk.data, spk.last} !== {word(3), 1'b1}) begin
            n_fail++;
            $display("FAIL start_ignored_last got %h/%b want %h/1", spk.data, spk.last, word(3));
        end
        wait_done("start_ignored");
    endtask

    task automatic test_reset_mid;
        do_reset();
        kick();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({spk.valid, spk.data} !== {1'b1, word(0)}) begin
            n_fail++;
            $display("FAIL rmid_pre got %b/%h want 1/%h", spk.valid, spk.data, word(0));
        end
        #1 rst_l = 1'b0;
        #1;
        n_checks++;
        if ({spk.valid, spk.data, rom_addr, sample_idx, layer_clear, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL rmid_async got v=%b d=%h a=%0d s=%0d c=%b b=%b dn=%b want all 0",
                     spk.valid, spk.data, rom_addr, sample_idx, layer_clear, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({spk.valid, rom_addr, busy} !== '0) begin
            n_fail++;
            $display("FAIL rmid_post got v=%b a=%0d b=%b want 0/0/0", spk.valid, rom_addr, busy);
        end
        spk.ready = 1'b1;
        kick();
        @(negedge clk);
        n_checks++;
        if (rom_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_restart_addr got %0d want 1", rom_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({spk.valid, spk.data, spk.step} !== {1'b1, word(0), 2'd0}) begin
            n_fail++;
            $display("FAIL rmid_restart_word got %b/%h/%0d want 1/%h/0",
                     spk.valid, spk.data, spk.step, word(0));
        end
        wait_done("reset_mid");
    endtask

`ifdef SPIKE_SEQ_LOOP_EN
    task automatic test_loop;
        do_reset();
        spk.ready = 1'b1;
        kick();
        repeat (19) @(negedge clk);
        n_checks++;
        if ({done, busy, rom_addr, sample_idx, epoch_cnt} !== {1'b1, 1'b1, 16'd0, 16'd0, 8'd1}) begin
            n_fail++;
            $display("FAIL loop_wrap got dn=%b b=%b a=%0d s=%0d e=%0d want 1/1/0/0/1",
                     done, busy, rom_addr, sample_idx, epoch_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({done, rom_addr, epoch_cnt} !== {1'b0, 16'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL loop_pulse got dn=%b a=%0d e=%0d want 0/1/1", done, rom_addr, epoch_cnt);
        end
    endtask
`endif

    initial begin
        spk.ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_start_ignored();
        test_reset_mid();
`ifdef SPIKE_SEQ_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
